// File: rtl/vga_digit_sequencer_if.sv
// Bundle of the control-to-sequencer signals and the digit outputs that go to the renderer.
// The master modport belongs to the controller; the sequencer uses the slave modport.
interface vga_digit_sequencer_if #(
    parameter int unsigned DIGIT_W = 4
);
    logic               frame_start;
    logic               run_en;
    logic               step_req;
    logic               dir;
    logic               load_valid;
    logic [DIGIT_W-1:0] load_digit;
    logic               load_ready;
    logic [DIGIT_W-1:0] digit;
    logic               digit_upd;
    logic               wrap_o;
    logic [1:0]         state_o;

    modport master (
        output frame_start, run_en, step_req, dir, load_valid, load_digit,
        input  load_ready, digit, digit_upd, wrap_o, state_o
    );

    modport slave (
        input  frame_start, run_en, step_req, dir, load_valid, load_digit,
        output load_ready, digit, digit_upd, wrap_o, state_o
    );
endinterface

// File: rtl/vga_digit_sequencer.sv
// Frame-synchronous digit sequencer: auto-steps in RUN, single-steps in PAUSE, loads via handshake.
// Optional build macro VGA_DIGIT_SEQ_PINGPONG_EN makes the digit bounce at the range ends.
module vga_digit_sequencer #(
    parameter int unsigned FRAMES_PER_STEP = 60,
    parameter int unsigned DIGIT_MAX       = 9,
    parameter int unsigned DIGIT_W         = 4
) (
    input logic                  clk,
    input logic                  rst,
    vga_digit_sequencer_if.slave seq_io
);
    localparam int unsigned        CntW     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CntW-1:0]    CntLast  = CntW'(FRAMES_PER_STEP - 1);
    localparam logic [DIGIT_W-1:0] DigitMax = DIGIT_W'(DIGIT_MAX);
    localparam logic [DIGIT_W-1:0] DigitOne = DIGIT_W'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               step_pend_q, step_pend_d;
    logic               load_pend_q, load_pend_d;
    logic [DIGIT_W-1:0] load_val_q, load_val_d;
    logic               upd_q, upd_d;
    logic               wrap_q, wrap_d;

    logic               load_ready;
    logic               load_fire;
    logic               advance;
    logic [DIGIT_W-1:0] adv_digit;
    logic               adv_wrap;

`ifdef VGA_DIGIT_SEQ_PINGPONG_EN
    logic dir_q, dir_d;
    logic adv_flip;

    // Bounce at the ends; with a single-value range the digit stays put but still flags a reversal.
    always_comb begin
        adv_digit = digit_q;
        adv_wrap  = 1'b0;
        adv_flip  = 1'b0;
        if (!dir_q) begin
            if (digit_q == DigitMax) begin
                adv_digit = (DigitMax == '0) ? '0 : DigitMax - DigitOne;
                adv_wrap  = 1'b1;
                adv_flip  = 1'b1;
            end else begin
                adv_digit = digit_q + DigitOne;
            end
        end else begin
            if (digit_q == '0) begin
                adv_digit = (DigitMax == '0) ? '0 : DigitOne;
                adv_wrap  = 1'b1;
                adv_flip  = 1'b1;
            end else begin
                adv_digit = digit_q - DigitOne;
            end
        end
    end
`else
    always_comb begin
        adv_digit = digit_q;
        adv_wrap  = 1'b0;
        if (!seq_io.dir) begin
            if (digit_q == DigitMax) begin
                adv_digit = '0;
                adv_wrap  = 1'b1;
            end else begin
                adv_digit = digit_q + DigitOne;
            end
        end else begin
            if (digit_q == '0) begin
                adv_digit = DigitMax;
                adv_wrap  = 1'b1;
            end else begin
                adv_digit = digit_q - DigitOne;
            end
        end
    end
`endif

    assign load_ready = (state_q != StRun) && !load_pend_q;
    assign load_fire  = seq_io.load_valid && load_ready;

    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        cnt_d       = cnt_q;
        step_pend_d = step_pend_q;
        load_pend_d = load_pend_q;
        load_val_d  = load_val_q;
        upd_d       = 1'b0;
        wrap_d      = 1'b0;
        advance     = 1'b0;
`ifdef VGA_DIGIT_SEQ_PINGPONG_EN
        dir_d       = dir_q;
`endif

        unique case (state_q)
            StIdle:  if (seq_io.run_en)  state_d = StRun;
            StRun:   if (!seq_io.run_en) state_d = StPause;
            StPause: if (seq_io.run_en)  state_d = StRun;
            default: state_d = StIdle;
        endcase

        if (state_q == StPause && seq_io.step_req) begin
            step_pend_d = 1'b1;
        end

        // The frame is always processed according to the state sampled in this cycle.
        if (seq_io.frame_start) begin
            if (load_pend_q) begin
                digit_d     = load_val_q;
                upd_d       = 1'b1;
                load_pend_d = 1'b0;
                step_pend_d = 1'b0;
                cnt_d       = '0;
            end else if (state_q == StRun) begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end else if (state_q == StPause && step_pend_q) begin
                advance     = 1'b1;
                step_pend_d = 1'b0;
            end
        end

        if (advance) begin
            digit_d = adv_digit;
            wrap_d  = adv_wrap;
            upd_d   = 1'b1;
`ifdef VGA_DIGIT_SEQ_PINGPONG_EN
            if (adv_flip) dir_d = ~dir_q;
`endif
        end

`ifdef VGA_DIGIT_SEQ_PINGPONG_EN
        // A fresh direction on entering RUN overrides any reversal from the same frame.
        if (state_q != StRun && state_d == StRun) dir_d = seq_io.dir;
`endif

        if (load_fire) begin
            load_pend_d = 1'b1;
            load_val_d  = (seq_io.load_digit > DigitMax) ? DigitMax : seq_io.load_digit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            digit_q     <= '0;
            cnt_q       <= '0;
            step_pend_q <= 1'b0;
            load_pend_q <= 1'b0;
            load_val_q  <= '0;
            upd_q       <= 1'b0;
            wrap_q      <= 1'b0;
`ifdef VGA_DIGIT_SEQ_PINGPONG_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            cnt_q       <= cnt_d;
            step_pend_q <= step_pend_d;
            load_pend_q <= load_pend_d;
            load_val_q  <= load_val_d;
            upd_q       <= upd_d;
            wrap_q      <= wrap_d;
`ifdef VGA_DIGIT_SEQ_PINGPONG_EN
            dir_q       <= dir_d;
`endif
        end
    end

    assign seq_io.load_ready = load_ready;
    assign seq_io.digit      = digit_q;
    assign seq_io.digit_upd  = upd_q;
    assign seq_io.wrap_o     = wrap_q;
    assign seq_io.state_o    = state_q;
endmodule

// File: tb/tb_vga_digit_sequencer.sv
// Scoreboard bench for vga_digit_sequencer: each frame that should change the digit queues
// the expected {wrap, digit}; a negedge monitor pops and compares on every digit_upd.
module tb_vga_digit_sequencer;
    localparam int unsigned Fps  = 2;
    localparam int unsigned DMax = 9;
    localparam int unsigned DW   = 4;
`ifdef VGA_DIGIT_SEQ_PINGPONG_EN
    localparam bit PingPong = 1'b1;
`else
    localparam bit PingPong = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_digit_sequencer_if #(.DIGIT_W(DW)) seq_if ();

    vga_digit_sequencer #(
        .FRAMES_PER_STEP(Fps),
        .DIGIT_MAX      (DMax),
        .DIGIT_W        (DW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .seq_io(seq_if)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [4:0] sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        seq_if.frame_start = 1'b1;
        tick();
        seq_if.frame_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic frame_exp(input logic [3:0] d, input logic w);
        sb_q.push_back({w, d});
        frame();
    endtask

    task automatic step_pulse();
        seq_if.step_req = 1'b1;
        tick();
        seq_if.step_req = 1'b0;
        tick();
    endtask

    task automatic do_load(input logic [3:0] v);
        check_val("load_ready_before", 32'(seq_if.load_ready), 32'd1);
        seq_if.load_valid = 1'b1;
        seq_if.load_digit = v;
        tick();
        seq_if.load_valid = 1'b0;
        check_val("load_ready_after", 32'(seq_if.load_ready), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (seq_if.digit_upd === 1'b1) begin
                check_val("upd_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    logic [4:0] e;
                    e = sb_q.pop_front();
                    check_val("digit", 32'(seq_if.digit), 32'(e[3:0]));
                    check_val("wrap", 32'(seq_if.wrap_o), 32'(e[4]));
                end
            end else if (seq_if.wrap_o !== 1'b0) begin
                check_val("wrap_without_upd", 32'(seq_if.wrap_o), 32'd0);
            end
        end
    end

    initial begin
        rst               = 1'b1;
        seq_if.frame_start = 1'b0;
        seq_if.run_en     = 1'b0;
        seq_if.step_req   = 1'b0;
        seq_if.dir        = 1'b0;
        seq_if.load_valid = 1'b0;
        seq_if.load_digit = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_val("rst_digit", 32'(seq_if.digit), 32'd0);
        check_val("rst_state", 32'(seq_if.state_o), 32'd0);
        check_val("rst_upd", 32'(seq_if.digit_upd), 32'd0);
        check_val("rst_wrap", 32'(seq_if.wrap_o), 32'd0);
        check_val("rst_ready", 32'(seq_if.load_ready), 32'd1);
        frame();  // IDLE: no update

        // Automatic stepping every second frame, one wrap at the top.
        seq_if.run_en = 1'b1;
        tick();
        check_val("state_run", 32'(seq_if.state_o), 32'd1);
        for (int i = 1; i <= 20; i++) begin
            if (i % 2 == 0) begin
                int k;
                k = i / 2;
                frame_exp((PingPong && k == 10) ? 4'd8 : 4'(k % 10), k == 10);
            end else begin
                frame();
            end
        end

        // PAUSE with frame_cnt=1: several step requests collapse into one step.
        frame();
        seq_if.run_en = 1'b0;
        tick();
        check_val("state_pause", 32'(seq_if.state_o), 32'd2);
        repeat (3) step_pulse();
        frame_exp(PingPong ? 4'd7 : 4'd1, 1'b0);
        seq_if.run_en = 1'b1;
        tick();
        frame_exp(PingPong ? 4'd8 : 4'd2, 1'b0);

        // Loads in PAUSE, including clamping and an unchanged value.
        seq_if.run_en = 1'b0;
        tick();
        do_load(4'd7);
        repeat (3) tick();
        check_val("ready_held_low", 32'(seq_if.load_ready), 32'd0);
        frame_exp(4'd7, 1'b0);
        check_val("digit_loaded7", 32'(seq_if.digit), 32'd7);
        check_val("ready_restored", 32'(seq_if.load_ready), 32'd1);
        do_load(4'd12);
        frame_exp(4'd9, 1'b0);
        do_load(4'd9);
        frame_exp(4'd9, 1'b0);

        // Load beats a pending step; the step is discarded.
        step_pulse();
        do_load(4'd4);
        frame_exp(4'd4, 1'b0);
        frame();
        check_val("digit_after_prio", 32'(seq_if.digit), 32'd4);
        seq_if.run_en = 1'b1;
        tick();
        seq_if.load_valid = 1'b1;
        seq_if.load_digit = 4'd3;
        for (int i = 0; i < 3; i++) begin
            check_val("ready_in_run", 32'(seq_if.load_ready), 32'd0);
            tick();
        end
        seq_if.load_valid = 1'b0;

        // Count down from 0, then reset with stale step and load pending.
        seq_if.run_en = 1'b0;
        tick();
        do_load(4'd0);
        frame_exp(4'd0, 1'b0);
        seq_if.dir    = 1'b1;
        seq_if.run_en = 1'b1;
        tick();
        frame();
        frame_exp(PingPong ? 4'd1 : 4'd9, 1'b1);
        frame();
        seq_if.run_en = 1'b0;
        tick();
        step_pulse();
        do_load(4'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_digit", 32'(seq_if.digit), 32'd0);
        check_val("mid_rst_state", 32'(seq_if.state_o), 32'd0);
        check_val("mid_rst_ready", 32'(seq_if.load_ready), 32'd1);
        tick();
        frame();
        check_val("no_stale_load", 32'(seq_if.digit), 32'd0);
        seq_if.run_en = 1'b1;
        tick();
        frame();
        frame_exp(PingPong ? 4'd1 : 4'd9, 1'b1);

        // Top-of-range behaviour: bounce or wrap depending on build.
        seq_if.run_en = 1'b0;
        tick();
        do_load(4'd8);
        frame_exp(4'd8, 1'b0);
        seq_if.dir    = 1'b0;
        seq_if.run_en = 1'b1;
        tick();
        frame();
        frame_exp(4'd9, 1'b0);
        frame();
        frame_exp(PingPong ? 4'd8 : 4'd0, 1'b1);
        frame();
        frame_exp(PingPong ? 4'd7 : 4'd1, 1'b0);

        repeat (5) tick();
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
